// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding, default geometry and frame-size helper for the capture controller
package cam_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} cap_state_t;
    localparam int H_PIXELS_DEF = 640;
    localparam int V_LINES_DEF  = 480;
    function automatic int frame_pixels(input int h, input int v);
        return h * v;
    endfunction
endpackage

// File: rtl/cam_if.sv
// cam_if: pixel stream into the capture controller and frame-buffer write port out of it
//   href, pixel_data, pixel_valid, frame_done : camera / pixel-assembly side
//   wr_en, wr_addr {bank, index}, wr_data     : frame-buffer RAM side
//   master = controller view, slave = environment view
interface cam_if #(parameter int PIX_ADDR_W = 19);
    logic                  href;
    logic [15:0]           pixel_data;
    logic                  pixel_valid;
    logic                  frame_done;
    logic                  wr_en;
    logic [PIX_ADDR_W:0]   wr_addr;
    logic [15:0]           wr_data;
    modport master (input href, pixel_data, pixel_valid, frame_done, output wr_en, wr_addr, wr_data);
    modport slave (output href, pixel_data, pixel_valid, frame_done, input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/cam_geom_check.sv
// cam_geom_check: href falling-edge detect, per-line pixel and line counters, sticky err_line
//   en          : counting enabled (controller in CAPTURE)
//   clr         : frame boundary, zero the counters
//   err_clr     : clear err_line (a coincident new error wins)
//   href, pixel_valid : raw line-valid and pixel strobe
//   line_end    : combinational, a line closes this cycle
//   line_cnt    : lines closed since clr
//   err_line    : sticky, some line had a pixel count other than H_PIXELS
module cam_geom_check #(
    parameter int H_PIXELS = 640
) (
    input  logic        p_clock,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        err_clr,
    input  logic        href,
    input  logic        pixel_valid,
    output logic        line_end,
    output logic [15:0] line_cnt,
    output logic        err_line
);
    logic        href_q;
    logic [15:0] col_cnt;
    logic [15:0] col_eff;
    assign line_end = en && href_q && !href;
    // a pixel arriving on the closing cycle still belongs to the line
    assign col_eff = col_cnt + 16'(pixel_valid);
    always_ff @(posedge p_clock) begin
        if (!rst_n) begin
            href_q   <= 1'b0;
            col_cnt  <= '0;
            line_cnt <= '0;
            err_line <= 1'b0;
        end else begin
            href_q   <= href;
            err_line <= (err_line && !err_clr) || (line_end && col_eff != 16'(H_PIXELS));
            if (clr) begin
                col_cnt  <= '0;
                line_cnt <= '0;
            end else if (line_end) begin
                col_cnt  <= '0;
                line_cnt <= line_cnt + 16'd1;
            end else if (en && pixel_valid) begin
                col_cnt  <= col_cnt + 16'd1;
            end
        end
    end
endmodule

// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl: arms on command, aligns to frame_done, writes pixels to a double-buffered frame store, checks geometry
//   cmd_start/cmd_cont/cmd_stop : arm (single or continuous) and stop at next frame boundary
//   err_clr                     : clear sticky error flags
//   bus (cam_if.master)         : pixel stream in, registered frame-buffer writes out
//   busy, frame_ready, rd_bank, frame_count, err_frame, err_line : status
module camera_capture_ctrl import cam_pkg::*; #(
    parameter int H_PIXELS   = H_PIXELS_DEF,
    parameter int V_LINES    = V_LINES_DEF,
    parameter int PIX_ADDR_W = 19,
    parameter int DOUBLE_BUF = 1
) (
    input  logic        p_clock,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic        cmd_cont,
    input  logic        cmd_stop,
    input  logic        err_clr,
    cam_if.master       bus,
    output logic        busy,
    output logic        frame_ready,
    output logic        rd_bank,
    output logic [15:0] frame_count,
    output logic        err_frame,
    output logic        err_line
);
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ARMED   = ARMED;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    // one extra bit so a frame filling the whole address space can still be recognised as exact
    localparam logic [PIX_ADDR_W:0] FRAME_PIX = (PIX_ADDR_W + 1)'(frame_pixels(H_PIXELS, V_LINES));
    logic [1:0]            state;
    logic                  cont, stop_pend, wr_bank;
    logic                  cap, wr_go, pix_inc, clr, eval, good, line_end;
    logic [PIX_ADDR_W:0]   pix_cnt, pix_next;
    logic [15:0]           line_cnt;
    logic                  wr_en_q;
    logic [PIX_ADDR_W:0]   wr_addr_q;
    logic [15:0]           wr_data_q;
    assign cap      = state == ST_CAPTURE;
    assign busy     = state != ST_IDLE;
    assign wr_go    = cap && bus.pixel_valid && pix_cnt < FRAME_PIX;
    assign pix_inc  = cap && bus.pixel_valid && pix_cnt != '1;
    assign pix_next = pix_cnt + (PIX_ADDR_W + 1)'(pix_inc);
    assign clr      = bus.frame_done && (state == ST_ARMED || cap);
    assign eval     = cap && bus.frame_done;
    // a pixel or line end coinciding with frame_done is counted before the check
    assign good     = pix_next == FRAME_PIX && line_cnt + 16'(line_end) == 16'(V_LINES);
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    cam_geom_check #(.H_PIXELS(H_PIXELS)) u_geom (
        .p_clock     (p_clock),
        .rst_n       (rst_n),
        .en          (cap),
        .clr         (clr),
        .err_clr     (err_clr),
        .href        (bus.href),
        .pixel_valid (bus.pixel_valid),
        .line_end    (line_end),
        .line_cnt    (line_cnt),
        .err_line    (err_line)
    );
    always_ff @(posedge p_clock) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cont        <= 1'b0;
            stop_pend   <= 1'b0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            pix_cnt     <= '0;
            frame_ready <= 1'b0;
            frame_count <= '0;
            err_frame   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_en_q     <= wr_go;
            frame_ready <= eval && good;
            err_frame   <= (err_frame && !err_clr) || (eval && !good);
            pix_cnt     <= clr ? '0 : pix_next;
            if (wr_go) begin
                wr_addr_q <= {wr_bank, pix_cnt[PIX_ADDR_W-1:0]};
                wr_data_q <= bus.pixel_data;
            end
            if (eval && good) begin
                frame_count <= frame_count + 16'd1;
                rd_bank     <= wr_bank;
                wr_bank     <= (DOUBLE_BUF != 0) ? !wr_bank : 1'b0;
            end
            if (state == ST_IDLE && cmd_start && !cmd_stop) begin
                state     <= ST_ARMED;
                cont      <= cmd_cont;
                stop_pend <= 1'b0;
            end else if (state == ST_ARMED) begin
                state <= cmd_stop ? ST_IDLE : bus.frame_done ? ST_CAPTURE : ST_ARMED;
            end else if (cap) begin
                if (bus.frame_done && (!cont || stop_pend || cmd_stop)) begin
                    state     <= ST_IDLE;
                    stop_pend <= 1'b0;
                end else if (cmd_stop) begin
                    stop_pend <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_camera_capture_ctrl.sv
// tb_camera_capture_ctrl: directed scenario tests for camera_capture_ctrl with a 4x3 frame
module tb_camera_capture_ctrl;
    logic        p_clock = 1'b0;
    logic        rst_n, cmd_start, cmd_cont, cmd_stop, err_clr;
    logic        busy, frame_ready, rd_bank, err_frame, err_line;
    logic [15:0] frame_count;
    logic [15:0] seq = 16'h1000;
    logic [4:0]  waddr[$];
    logic [15:0] wdata[$];
    int          fr_total = 0;
    int          tests = 0;
    int          fails = 0;
    int          wbase, fbase;
    cam_if #(.PIX_ADDR_W(4)) bus ();
    camera_capture_ctrl #(.H_PIXELS(4), .V_LINES(3), .PIX_ADDR_W(4), .DOUBLE_BUF(1)) dut (
        .p_clock     (p_clock),
        .rst_n       (rst_n),
        .cmd_start   (cmd_start),
        .cmd_cont    (cmd_cont),
        .cmd_stop    (cmd_stop),
        .err_clr     (err_clr),
        .bus         (bus.master),
        .busy        (busy),
        .frame_ready (frame_ready),
        .rd_bank     (rd_bank),
        .frame_count (frame_count),
        .err_frame   (err_frame),
        .err_line    (err_line)
    );
    always #5 p_clock = ~p_clock;
    always @(negedge p_clock) begin
        if (bus.wr_en) begin
            waddr.push_back(bus.wr_addr);
            wdata.push_back(bus.wr_data);
        end
        if (frame_ready) fr_total++;
    end
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge p_clock);
            #1;
        end
    endtask
    task automatic mark();
        wbase = waddr.size();
        fbase = fr_total;
    endtask
    task automatic do_reset();
        rst_n = 1'b0; cmd_start = 1'b0; cmd_cont = 1'b0; cmd_stop = 1'b0; err_clr = 1'b0;
        bus.href = 1'b0; bus.pixel_valid = 1'b0; bus.frame_done = 1'b0; bus.pixel_data = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc();
        mark();
    endtask
    task automatic start(input logic cont);
        cmd_start = 1'b1; cmd_cont = cont;
        cyc();
        cmd_start = 1'b0; cmd_cont = 1'b0;
    endtask
    task automatic pulse_fd();
        bus.frame_done = 1'b1;
        cyc();
        bus.frame_done = 1'b0;
        cyc();
    endtask
    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            bus.href = 1'b1; bus.pixel_valid = 1'b1; bus.pixel_data = seq;
            seq = seq + 16'd1;
            cyc();
        end
        bus.href = 1'b0; bus.pixel_valid = 1'b0;
        cyc();
    endtask
    task automatic send_good_frame();
        repeat (3) send_line(4);
        pulse_fd();
    endtask
    task automatic test_reset();
        do_reset();
        tests++; if ({busy, frame_ready, rd_bank, err_frame, err_line} !== 5'b0) begin fails++; $display("FAIL reset_flags: got %b exp 00000", {busy, frame_ready, rd_bank, err_frame, err_line}); end
        tests++; if (frame_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d exp 0", frame_count); end
        tests++; if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== 22'd0) begin fails++; $display("FAIL reset_wr: got %0h exp 0", {bus.wr_en, bus.wr_addr, bus.wr_data}); end
    endtask
    task automatic test_single_shot();
        logic [15:0] d0;
        do_reset();
        start(1'b0);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_armed_busy: got %b exp 1", busy); end
        pulse_fd();
        mark();
        d0 = seq;
        send_good_frame();
        tests++; if (waddr.size() - wbase !== 12) begin fails++; $display("FAIL single_nwrites: got %0d exp 12", waddr.size() - wbase); end
        else for (int i = 0; i < 12; i++) begin
            tests++; if (waddr[wbase + i] !== 5'(i)) begin fails++; $display("FAIL single_addr%0d: got %0h exp %0h", i, waddr[wbase + i], i); end
        end
        if (waddr.size() - wbase >= 12) begin
            tests++; if (wdata[wbase] !== d0 || wdata[wbase + 11] !== d0 + 16'd11) begin fails++; $display("FAIL single_data: got %h/%h exp %h/%h", wdata[wbase], wdata[wbase + 11], d0, d0 + 16'd11); end
        end
        tests++; if (fr_total - fbase !== 1) begin fails++; $display("FAIL single_ready: got %0d exp 1", fr_total - fbase); end
        tests++; if (frame_count !== 16'd1) begin fails++; $display("FAIL single_count: got %0d exp 1", frame_count); end
        tests++; if (busy !== 1'b0 || rd_bank !== 1'b0) begin fails++; $display("FAIL single_idle: got busy=%b rd_bank=%b exp 0 0", busy, rd_bank); end
        tests++; if (err_frame !== 1'b0 || err_line !== 1'b0) begin fails++; $display("FAIL single_err: got %b%b exp 00", err_frame, err_line); end
    endtask
    task automatic test_continuous();
        do_reset();
        start(1'b1);
        pulse_fd();
        for (int f = 0; f < 3; f++) begin
            mark();
            send_good_frame();
            tests++; if (waddr.size() - wbase !== 12) begin fails++; $display("FAIL cont_nwrites%0d: got %0d exp 12", f, waddr.size() - wbase); end
            else for (int i = 0; i < 12; i++) begin
                tests++; if (waddr[wbase + i] !== {1'(f % 2), 4'(i)}) begin fails++; $display("FAIL cont_addr%0d_%0d: got %0h exp %0h", f, i, waddr[wbase + i], {1'(f % 2), 4'(i)}); end
            end
            tests++; if (rd_bank !== 1'(f % 2)) begin fails++; $display("FAIL cont_rdbank%0d: got %b exp %b", f, rd_bank, 1'(f % 2)); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL cont_busy%0d: got %b exp 1", f, busy); end
        end
        tests++; if (frame_count !== 16'd3) begin fails++; $display("FAIL cont_count: got %0d exp 3", frame_count); end
    endtask
    task automatic test_short_frame();
        do_reset();
        start(1'b1);
        pulse_fd();
        mark();
        send_line(3);
        pulse_fd();
        tests++; if (err_line !== 1'b1 || err_frame !== 1'b1) begin fails++; $display("FAIL short_err: got line=%b frame=%b exp 1 1", err_line, err_frame); end
        tests++; if (fr_total - fbase !== 0 || rd_bank !== 1'b0) begin fails++; $display("FAIL short_noready: got ready=%0d rd_bank=%b exp 0 0", fr_total - fbase, rd_bank); end
        mark();
        send_good_frame();
        tests++; if (waddr.size() - wbase !== 12) begin fails++; $display("FAIL short_next_nwrites: got %0d exp 12", waddr.size() - wbase); end
        else begin
            tests++; if (waddr[wbase] !== 5'd0 || waddr[wbase + 11] !== 5'd11) begin fails++; $display("FAIL short_next_bank: got %0h..%0h exp 0..b", waddr[wbase], waddr[wbase + 11]); end
        end
        tests++; if (fr_total - fbase !== 1 || rd_bank !== 1'b0) begin fails++; $display("FAIL short_next_ready: got ready=%0d rd_bank=%b exp 1 0", fr_total - fbase, rd_bank); end
        tests++; if (err_line !== 1'b1 || err_frame !== 1'b1) begin fails++; $display("FAIL short_sticky: got %b%b exp 11", err_line, err_frame); end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        cyc();
        tests++; if (err_line !== 1'b0 || err_frame !== 1'b0) begin fails++; $display("FAIL short_clr: got %b%b exp 00", err_line, err_frame); end
    endtask
    task automatic test_long_frame();
        do_reset();
        start(1'b0);
        pulse_fd();
        mark();
        repeat (3) send_line(4);
        send_line(2);
        pulse_fd();
        tests++; if (waddr.size() - wbase !== 12) begin fails++; $display("FAIL long_nwrites: got %0d exp 12", waddr.size() - wbase); end
        else begin
            tests++; if (waddr[wbase + 11] !== 5'd11) begin fails++; $display("FAIL long_lastaddr: got %0h exp b", waddr[wbase + 11]); end
        end
        tests++; if (err_frame !== 1'b1 || fr_total - fbase !== 0) begin fails++; $display("FAIL long_err: got err=%b ready=%0d exp 1 0", err_frame, fr_total - fbase); end
        tests++; if (busy !== 1'b0 || frame_count !== 16'd0) begin fails++; $display("FAIL long_idle: got busy=%b count=%0d exp 0 0", busy, frame_count); end
    endtask
    task automatic test_stop_and_ignore();
        do_reset();
        start(1'b1);
        pulse_fd();
        send_line(4);
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stop_midframe_busy: got %b exp 1", busy); end
        repeat (2) send_line(4);
        pulse_fd();
        tests++; if (fr_total - fbase !== 1 || frame_count !== 16'd1) begin fails++; $display("FAIL stop_ready: got ready=%0d count=%0d exp 1 1", fr_total - fbase, frame_count); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_idle: got %b exp 0", busy); end
        start(1'b1);
        pulse_fd();
        repeat (3) send_line(4);
        cmd_start = 1'b1; cmd_cont = 1'b0; bus.frame_done = 1'b1;
        cyc();
        cmd_start = 1'b0; bus.frame_done = 1'b0;
        cyc();
        tests++; if (busy !== 1'b1 || frame_count !== 16'd2) begin fails++; $display("FAIL start_ignored: got busy=%b count=%0d exp 1 2", busy, frame_count); end
        send_good_frame();
        tests++; if (busy !== 1'b1 || frame_count !== 16'd3) begin fails++; $display("FAIL start_ignored_cont: got busy=%b count=%0d exp 1 3", busy, frame_count); end
    endtask
    task automatic test_reset_midline();
        do_reset();
        start(1'b1);
        pulse_fd();
        bus.href = 1'b1; bus.pixel_valid = 1'b1;
        cyc(2);
        tests++; if (bus.wr_en !== 1'b1) begin fails++; $display("FAIL rst_pre_wr: got %b exp 1", bus.wr_en); end
        rst_n = 1'b0;
        cyc();
        tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %b exp 0", bus.wr_en); end
        tests++; if ({busy, frame_ready, rd_bank, err_frame, err_line, frame_count, bus.wr_addr, bus.wr_data} !== 42'd0) begin fails++; $display("FAIL rst_outputs: got %0h exp 0", {busy, frame_ready, rd_bank, err_frame, err_line, frame_count, bus.wr_addr, bus.wr_data}); end
        rst_n = 1'b1; bus.href = 1'b0; bus.pixel_valid = 1'b0;
        cyc();
        start(1'b0);
        mark();
        send_line(4);
        tests++; if (waddr.size() - wbase !== 0) begin fails++; $display("FAIL rst_armed_nowrite: got %0d exp 0", waddr.size() - wbase); end
        pulse_fd();
        mark();
        send_good_frame();
        tests++; if (waddr.size() - wbase !== 12 || fr_total - fbase !== 1) begin fails++; $display("FAIL rst_realign: got writes=%0d ready=%0d exp 12 1", waddr.size() - wbase, fr_total - fbase); end
        tests++; if (err_frame !== 1'b0 || err_line !== 1'b0) begin fails++; $display("FAIL rst_realign_err: got %b%b exp 00", err_frame, err_line); end
    endtask
    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_short_frame();
        test_long_frame();
        test_stop_and_ignore();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
